reservation_station: RTL and testbench
======================================

// Module: reservation_station
// PURPOSE
// - Receiving end of the dispatcher->RS interface in the Tomasulo core; one instance per FU class (Int, Mult, Branch, LdSt).
// - Accepts INST_RS entries when its RS_load bit is high and reports is_full back as RS_is_full[i].
// - Snoops the CDB to wake pending operands, picks the oldest fully-ready entry and presents it to its FU.
// - FU handoff is a registered valid/ready issue stage.
// PARAMETERS
// - RS_SIZE      4            number of entries (>=2)
// - XLEN         `XLEN        operand width
// - ROB_TAG_LEN  `ROB_TAG_LEN ROB tag width
// PORTS
// - clk          in   1            single clock; all state updates on posedge
// - reset        in   1            synchronous, active-high
// - load         in   1            dispatcher write strobe (RS_load[i])
// - inst_in      in   INST_RS      fu, func, imm, pc, tag_dest, tag/ready/value src1 and src2
// - is_full      out  1            all entries valid; drives RS_is_full[i]
// - cdb_valid    in   1            CDB broadcast valid
// - cdb_tag      in   ROB_TAG_LEN  ROB tag of the broadcast result
// - cdb_value    in   XLEN         broadcast result
// - squash       in   1            mispredict flush
// - issue_valid  out  1            issue_inst holds a ready instruction
// - issue_ready  in   1            FU accepts issue_inst this cycle
// - issue_inst   out  INST_RS      instruction with both operands ready and valued
// BEHAVIOUR
// - Reset: all entry valid bits=0, age matrix=0, issue_valid=0, issue_inst='0, is_full=0.
//   Reset overrides every other input.
// - Priority per edge: reset > squash > {allocate, wakeup, select}.
// - squash: next edge clears all entries and issue_valid; load and cdb ignored that cycle.
// - is_full = &valid. It is combinational from registered state only.
//   A slot freed by issue this cycle does not clear is_full until the next cycle.
// - Allocate: load && !is_full -> write inst_in to the lowest-index free entry and mark it youngest.
//   load while is_full is dropped and state is unchanged. The dispatcher must never do this; flag it with an assertion.
// - Allocation bypass: for each src with ready_srcN=0 where cdb_valid && cdb_tag==tag_srcN,
//   store ready=1 and value=cdb_value in the same edge.
// - Wakeup: each valid entry, each src with ready=0 and a matching cdb tag -> ready=1, value=cdb_value.
//   - Multiple entries can match at once.
//   - An already-ready src is never overwritten.
// - Select: among valid entries with both srcs ready (registered bits), pick the oldest via the age matrix.
//   - Operands woken this edge become eligible next cycle.
// - Issue stage, 1 deep: advance = !issue_valid || issue_ready.
//   - On advance with a selected entry: issue_inst<=entry, issue_valid<=1, entry valid<=0 (same edge).
//   - On advance with no candidate: issue_valid<=0.
//   - When !advance: issue_inst and issue_valid hold stable, with no entry freed.
// - Latency: an entry allocated with both srcs ready at edge E0 -> issue_valid=1 after E1.
//   An entry woken by the CDB at edge Ew -> issues at Ew+1 at the earliest.
// - Simultaneous alloc and free in one cycle is legal.
//   The new entry must not take the slot being freed that same edge; it uses the lowest free slot per pre-edge valid bits.
// - Age matrix: older[i][j]=1 iff entry i was allocated before entry j.
//   On allocating k: set older[j][k] for all valid j; clear row k.
// STRUCTURE
// - Shared header (dispatcher.svh / rs.svh): INST_RS, RS_ENTRY {valid, INST_RS}, RS_SIZE default, FU enum.
// - Sub-module rs_select: combinational, ready vector + age matrix -> one-hot grant + any_grant.
// - Top level: entry array, alloc priority encoder, CDB compare per src, issue register.
// TESTING
// - Reset then idle -> issue_valid=0, is_full=0; load one entry (both ready, tag_dest=3) -> issue_valid=1 after 1 edge, tag_dest=3.
// - Load 4 entries tag_src1=5 not ready -> is_full=1, 5th load dropped;
//   cdb tag=5 value=32'hDEAD -> all wake and issue in allocation order with value_src1=32'hDEAD.
// - Load with tag_src2=7 while cdb_valid tag=7 value=42 in same cycle -> entry stored ready, value_src2=42, issues next edge.
// - issue_ready=0 for 3 cycles with a ready entry -> issue_inst stable, that entry stays valid;
//   issue_ready=1 -> handoff, next-oldest follows.
// - Full RS, issue frees slot 2 and load high same cycle -> load dropped (is_full=1 pre-edge); next-cycle load lands in slot 2.
// - squash with 3 entries and issue_valid=1 -> next cycle all invalid, issue_valid=0, is_full=0; a load that cycle is ignored.

Source files
------------

// File: rtl/reservation_station_pkg.sv
// Shared types for the dispatcher -> reservation station interface.
// Holds the instruction payload, the RS entry wrapper and the CDB capture helper.
package reservation_station_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned ROB_TAG_LEN     = 4;
    localparam int unsigned FUNC_LEN        = 4;
    localparam int unsigned RS_SIZE_DEFAULT = 4;

    typedef enum logic [1:0] {
        FU_INT    = 2'd0,
        FU_MULT   = 2'd1,
        FU_BRANCH = 2'd2,
        FU_LDST   = 2'd3
    } fu_e;

    typedef struct packed {
        fu_e                    fu;
        logic [FUNC_LEN-1:0]    func;
        logic [XLEN-1:0]        imm;
        logic [XLEN-1:0]        pc;
        logic [ROB_TAG_LEN-1:0] tag_dest;
        logic [ROB_TAG_LEN-1:0] tag_src1;
        logic                   ready_src1;
        logic [XLEN-1:0]        value_src1;
        logic [ROB_TAG_LEN-1:0] tag_src2;
        logic                   ready_src2;
        logic [XLEN-1:0]        value_src2;
    } inst_rs_t;

    typedef struct packed {
        logic     valid;
        inst_rs_t inst;
    } rs_entry_t;

    // Capture a CDB broadcast into any still-pending source; ready sources are never overwritten.
    function automatic inst_rs_t cdb_capture(
        input inst_rs_t               inst,
        input logic                   cdb_valid,
        input logic [ROB_TAG_LEN-1:0] cdb_tag,
        input logic [XLEN-1:0]        cdb_value
    );
        inst_rs_t res;
        res = inst;
        if (cdb_valid && !res.ready_src1 && (res.tag_src1 == cdb_tag)) begin
            res.ready_src1 = 1'b1;
            res.value_src1 = cdb_value;
        end
        if (cdb_valid && !res.ready_src2 && (res.tag_src2 == cdb_tag)) begin
            res.ready_src2 = 1'b1;
            res.value_src2 = cdb_value;
        end
        return res;
    endfunction

endpackage

// File: rtl/reservation_station_rs_select.sv
// Oldest-ready picker: grants the ready entry that no other ready entry is older than.
module rs_select #(
    parameter int unsigned RS_SIZE = 4
) (
    input  logic [RS_SIZE-1:0]              ready,
    input  logic [RS_SIZE-1:0][RS_SIZE-1:0] older,
    output logic [RS_SIZE-1:0]              grant_c,
    output logic                            any_grant_c
);

    always_comb begin
        grant_c = '0;
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            grant_c[i] = ready[i];
            for (int j = 0; j < int'(RS_SIZE); j++) begin
                if ((j != i) && ready[j] && older[j][i]) begin
                    grant_c[i] = 1'b0;
                end
            end
        end
        any_grant_c = |ready;
    end

endmodule

// File: rtl/reservation_station.sv
// Reservation station for one FU class: allocation, CDB wakeup, oldest-ready select
// and a one-deep registered valid/ready issue stage toward the FU.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int unsigned RS_SIZE = RS_SIZE_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  inst_rs_t               inst_in,
    output logic                   is_full,
    input  logic                   cdb_valid,
    input  logic [ROB_TAG_LEN-1:0] cdb_tag,
    input  logic [XLEN-1:0]        cdb_value,
    input  logic                   squash,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output inst_rs_t               issue_inst
);

    localparam int unsigned IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    rs_entry_t                       entries [RS_SIZE];
    logic [RS_SIZE-1:0][RS_SIZE-1:0] older;
    logic [RS_SIZE-1:0]              entry_valid;
    logic [RS_SIZE-1:0]              src_ready;
    logic [RS_SIZE-1:0]              grant;
    logic                            any_grant;
    logic [IDX_W-1:0]                alloc_idx;
    logic [IDX_W-1:0]                grant_idx;
    logic                            alloc_en;
    logic                            advance;
    inst_rs_t                        alloc_inst;

    always_comb begin
        entry_valid = '0;
        src_ready   = '0;
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            entry_valid[i] = entries[i].valid;
            src_ready[i]   = entries[i].valid && entries[i].inst.ready_src1
                             && entries[i].inst.ready_src2;
        end
    end

    assign is_full = &entry_valid;

    // Lowest free slot by pre-edge valid bits, so a slot freed by issue this edge is never reused at once.
    always_comb begin
        alloc_idx = '0;
        for (int i = int'(RS_SIZE) - 1; i >= 0; i--) begin
            if (!entry_valid[i]) begin
                alloc_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            if (grant[i]) begin
                grant_idx = IDX_W'(i);
            end
        end
    end

    assign alloc_en   = load && !is_full;
    assign advance    = !issue_valid || issue_ready;
    assign alloc_inst = cdb_capture(inst_in, cdb_valid, cdb_tag, cdb_value);

    rs_select #(
        .RS_SIZE(RS_SIZE)
    ) u_select (
        .ready      (src_ready),
        .older      (older),
        .grant_c    (grant),
        .any_grant_c(any_grant)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                entries[i] <= '0;
            end
            older       <= '0;
            issue_valid <= 1'b0;
            issue_inst  <= '0;
        end else if (squash) begin
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                entries[i].valid <= 1'b0;
            end
            issue_valid <= 1'b0;
        end else begin
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                if (entries[i].valid) begin
                    entries[i].inst <= cdb_capture(entries[i].inst, cdb_valid, cdb_tag, cdb_value);
                end
            end

            if (advance) begin
                if (any_grant) begin
                    issue_inst                <= entries[grant_idx].inst;
                    issue_valid               <= 1'b1;
                    entries[grant_idx].valid  <= 1'b0;
                end else begin
                    issue_valid <= 1'b0;
                end
            end

            // New entry becomes youngest: every currently valid entry is older than it.
            if (alloc_en) begin
                entries[alloc_idx].valid <= 1'b1;
                entries[alloc_idx].inst  <= alloc_inst;
                older[alloc_idx]         <= '0;
                for (int j = 0; j < int'(RS_SIZE); j++) begin
                    if (entry_valid[j]) begin
                        older[j][alloc_idx] <= 1'b1;
                    end
                end
            end
        end
    end

    load_when_full_a : assert property (@(posedge clk) disable iff (reset || squash) !(load && is_full))
        else $warning("reservation_station: load while full was dropped");

endmodule

// File: tb/tb_reservation_station.sv
// Directed table-driven bench for reservation_station with a hand-written full/free sequence.
module tb_reservation_station;
    import reservation_station_pkg::*;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   load;
    inst_rs_t               inst_in;
    logic                   is_full;
    logic                   cdb_valid;
    logic [ROB_TAG_LEN-1:0] cdb_tag;
    logic [XLEN-1:0]        cdb_value;
    logic                   squash;
    logic                   issue_valid;
    logic                   issue_ready;
    inst_rs_t               issue_inst;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rst;
        logic        load;
        logic [3:0]  dest;
        logic [3:0]  ts1;
        logic        r1;
        logic [3:0]  ts2;
        logic        r2;
        logic        cv;
        logic [3:0]  ct;
        logic [31:0] cval;
        logic        sq;
        logic        irdy;
        logic        e_iv;
        logic [3:0]  e_dest;
        logic        e_full;
        logic        chk_val;
        logic [31:0] e_v1;
        logic [31:0] e_v2;
    } vec_t;

    vec_t       tv [34];
    vec_t       hs [14];
    logic [3:0] hv [14];

    reservation_station dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .inst_in    (inst_in),
        .is_full    (is_full),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_value  (cdb_value),
        .squash     (squash),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .issue_inst (issue_inst)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, got, exp);
        end
    endtask

    // Drive one vector at negedge, let one posedge happen, then compare just after it.
    task automatic apply(input string grp, input int idx, input vec_t v);
        @(negedge clk);
        reset               = v.rst;
        load                = v.load;
        inst_in             = '0;
        inst_in.fu          = FU_INT;
        inst_in.pc          = 32'h1000 + 32'(v.dest);
        inst_in.tag_dest    = v.dest;
        inst_in.tag_src1    = v.ts1;
        inst_in.ready_src1  = v.r1;
        inst_in.value_src1  = v.r1 ? (32'h100 + 32'(v.dest)) : 32'h0;
        inst_in.tag_src2    = v.ts2;
        inst_in.ready_src2  = v.r2;
        inst_in.value_src2  = v.r2 ? (32'h200 + 32'(v.dest)) : 32'h0;
        cdb_valid           = v.cv;
        cdb_tag             = v.ct;
        cdb_value           = v.cval;
        squash              = v.sq;
        issue_ready         = v.irdy;
        @(posedge clk);
        #1;
        check({grp, " issue_valid"}, idx, 32'(issue_valid), 32'(v.e_iv));
        check({grp, " is_full"}, idx, 32'(is_full), 32'(v.e_full));
        if (v.e_iv) begin
            check({grp, " tag_dest"}, idx, 32'(issue_inst.tag_dest), 32'(v.e_dest));
        end
        if (v.e_iv && v.chk_val) begin
            check({grp, " value_src1"}, idx, issue_inst.value_src1, v.e_v1);
            check({grp, " value_src2"}, idx, issue_inst.value_src2, v.e_v2);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; load = 1'b0; inst_in = '0; cdb_valid = 1'b0;
        cdb_tag = '0; cdb_value = '0; squash = 1'b0; issue_ready = 1'b1;

        //          rst ld dst ts1 r1 ts2 r2  cv ct cval     sq irdy  iv dst full chk v1        v2
        // reset, idle, single ready entry issues one edge after allocation
        tv[0]  = '{1, 0, 0,  0, 0, 0, 0,  0, 0, 0,       0, 1,    0, 0,  0,  0, 0,        0};
        tv[1]  = '{0, 0, 0,  0, 0, 0, 0,  0, 0, 0,       0, 1,    0, 0,  0,  0, 0,        0};
        tv[2]  = '{0, 1, 3,  0, 1, 0, 1,  0, 0, 0,       0, 1,    0, 0,  0,  0, 0,        0};
        tv[3]  = '{0, 0, 0,  0, 0, 0, 0,  0, 0, 0,       0, 1,    1, 3,  0,  1, 'h103,    'h203};
        tv[4]  = '{0, 0, 0,  0, 0, 0, 0,  0, 0, 0,       0, 1,    0, 0,  0,  0, 0,        0};
        // fill with src1 waiting on tag 5, drop a 5th load, broadcast, drain in allocation order
        tv[5]  = '{0, 1, 8,  5, 0, 0, 1,  0, 0, 0,       0, 1,    0, 0,  0,  0, 0,        0};
        tv[6]  = '{0, 1, 9,  5, 0, 0, 1,  0, 0, 0,       0, 1,    0, 0,  0,  0, 0,        0};
        tv[7]  = '{0, 1, 10, 5, 0, 0, 1,  0, 0, 0,       0, 1,    0, 0,  0,  0, 0,        0};
        tv[8]  = '{0, 1, 11, 5, 0, 0, 1,  0, 0, 0,       0, 1,    0, 0,  1,  0, 0,        0};
        tv[9]  = '{0, 1, 12, 0, 1, 0, 1,  0, 0, 0,       0, 1,    0, 0,  1,  0, 0,        0};
        tv[10] = '{0, 0, 0,  0, 0, 0, 0,  1, 5, 'hDEAD,  0, 1,    0, 0,  1,  0, 0,        0};
        tv[11] = '{0, 0, 0,  0, 0, 0, 0,  0, 0, 0,       0, 1,    1, 8,  0,  1, 'hDEAD,   'h208};
        tv[12] = '{0, 0, 0,  0, 0, 0, 0,  0, 0, 0,       0, 1,    1, 9,  0,  1, 'hDEAD,   'h209};
        tv[13] = '{0, 0, 0,  0, 0, 0, 0,  0, 0, 0,       0, 1,    1, 10, 0,  1, 'hDEAD,   'h20A};
        tv[14] = '{0, 0, 0,  0, 0, 0, 0,  0, 0, 0,       0, 1,    1, 11, 0,  1, 'hDEAD,   'h20B};
        tv[15] = '{0, 0, 0,  0, 0, 0, 0,  0, 0, 0,       0, 1,    0, 0,  0,  0, 0,        0};
        // allocation bypass: src2 tag 7 broadcast on the same edge as the load
        tv[16] = '{0, 1, 4,  0, 1, 7, 0,  1, 7, 42,      0, 1,    0, 0,  0,  0, 0,        0};
        tv[17] = '{0, 0, 0,  0, 0, 0, 0,  0, 0, 0,       0, 1,    1, 4,  0,  1, 'h104,    42};
        tv[18] = '{0, 0, 0,  0, 0, 0, 0,  0, 0, 0,       0, 1,    0, 0,  0,  0, 0,        0};
        // FU stall: issue register holds for three cycles, then next-oldest follows
        tv[19] = '{0, 1, 1,  0, 1, 0, 1,  0, 0, 0,       0, 0,    0, 0,  0,  0, 0,        0};
        tv[20] = '{0, 1, 2,  0, 1, 0, 1,  0, 0, 0,       0, 0,    1, 1,  0,  1, 'h101,    'h201};
        tv[21] = '{0, 0, 0,  0, 0, 0, 0,  0, 0, 0,       0, 0,    1, 1,  0,  1, 'h101,    'h201};
        tv[22] = '{0, 0, 0,  0, 0, 0, 0,  0, 0, 0,       0, 0,    1, 1,  0,  1, 'h101,    'h201};
        tv[23] = '{0, 0, 0,  0, 0, 0, 0,  0, 0, 0,       0, 0,    1, 1,  0,  1, 'h101,    'h201};
        tv[24] = '{0, 0, 0,  0, 0, 0, 0,  0, 0, 0,       0, 1,    1, 2,  0,  1, 'h102,    'h202};
        tv[25] = '{0, 0, 0,  0, 0, 0, 0,  0, 0, 0,       0, 1,    0, 0,  0,  0, 0,        0};
        // squash with three entries and a held issue; the concurrent load and cdb are ignored
        tv[26] = '{0, 1, 5,  9, 0, 0, 1,  0, 0, 0,       0, 1,    0, 0,  0,  0, 0,        0};
        tv[27] = '{0, 1, 6,  9, 0, 0, 1,  0, 0, 0,       0, 1,    0, 0,  0,  0, 0,        0};
        tv[28] = '{0, 1, 7,  0, 1, 0, 1,  0, 0, 0,       0, 1,    0, 0,  0,  0, 0,        0};
        tv[29] = '{0, 1, 13, 9, 0, 0, 1,  0, 0, 0,       0, 0,    1, 7,  0,  1, 'h107,    'h207};
        tv[30] = '{0, 1, 14, 0, 1, 0, 1,  1, 9, 'h99,    1, 0,    0, 0,  0,  0, 0,        0};
        tv[31] = '{0, 0, 0,  0, 0, 0, 0,  0, 0, 0,       0, 1,    0, 0,  0,  0, 0,        0};
        tv[32] = '{0, 0, 0,  0, 0, 0, 0,  1, 9, 'h99,    0, 1,    0, 0,  0,  0, 0,        0};
        tv[33] = '{0, 0, 0,  0, 0, 0, 0,  0, 0, 0,       0, 1,    0, 0,  0,  0, 0,        0};

        for (int i = 0; i < 34; i++) begin
            apply("table", i, tv[i]);
        end

        // Full RS while the FU is stalled; slot 2 frees on the same edge as a dropped load.
        hs[0]  = '{1, 1, 15, 0, 1, 0, 1,  0, 0, 0,       0, 0,    0, 0,  0,  0, 0,        0};
        hs[1]  = '{0, 1, 15, 0, 1, 0, 1,  0, 0, 0,       0, 0,    0, 0,  0,  0, 0,        0};
        hs[2]  = '{0, 0, 0,  0, 0, 0, 0,  0, 0, 0,       0, 0,    1, 15, 0,  1, 'h10F,    'h20F};
        hs[3]  = '{0, 1, 1,  3, 0, 0, 1,  0, 0, 0,       0, 0,    1, 15, 0,  1, 'h10F,    'h20F};
        hs[4]  = '{0, 1, 2,  3, 0, 0, 1,  0, 0, 0,       0, 0,    1, 15, 0,  0, 0,        0};
        hs[5]  = '{0, 1, 3,  0, 1, 0, 1,  0, 0, 0,       0, 0,    1, 15, 0,  0, 0,        0};
        hs[6]  = '{0, 1, 4,  3, 0, 0, 1,  0, 0, 0,       0, 0,    1, 15, 1,  0, 0,        0};
        hs[7]  = '{0, 1, 5,  0, 1, 0, 1,  0, 0, 0,       0, 1,    1, 3,  0,  1, 'h103,    'h203};
        hs[8]  = '{0, 1, 6,  0, 1, 0, 1,  0, 0, 0,       0, 0,    1, 3,  1,  0, 0,        0};
        hs[9]  = '{0, 0, 0,  0, 0, 0, 0,  1, 3, 'h33,    0, 1,    1, 6,  0,  1, 'h106,    'h206};
        hs[10] = '{0, 0, 0,  0, 0, 0, 0,  0, 0, 0,       0, 1,    1, 1,  0,  1, 'h33,     'h201};
        hs[11] = '{0, 0, 0,  0, 0, 0, 0,  0, 0, 0,       0, 1,    1, 2,  0,  1, 'h33,     'h202};
        hs[12] = '{0, 0, 0,  0, 0, 0, 0,  0, 0, 0,       0, 1,    1, 4,  0,  1, 'h33,     'h204};
        hs[13] = '{0, 0, 0,  0, 0, 0, 0,  0, 0, 0,       0, 1,    0, 0,  0,  0, 0,        0};
        hv[0] = 4'b0000; hv[1]  = 4'b0001; hv[2]  = 4'b0000; hv[3]  = 4'b0001;
        hv[4] = 4'b0011; hv[5]  = 4'b0111; hv[6]  = 4'b1111; hv[7]  = 4'b1011;
        hv[8] = 4'b1111; hv[9]  = 4'b1011; hv[10] = 4'b1010; hv[11] = 4'b1000;
        hv[12] = 4'b0000; hv[13] = 4'b0000;

        for (int i = 0; i < 14; i++) begin
            apply("fullfree", i, hs[i]);
            check("fullfree entry_valid", i, 32'(dut.entry_valid), 32'(hv[i]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
